sequencer: RTL and testbench
============================

SEQUENCER -- requirements
Module: sequencer

Interface
REQ-001 Parameter DEPTH, default 4, return-stack entries (power of 2, 2..16).
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 run  input  1  level enable; high permits instruction issue.
REQ-005 imem_data  input  8  instruction word: [7:4] opcode, [3:0] operand.
REQ-006 imem_ready  input  1  imem_data valid this cycle.
REQ-007 pc  input  8  current program counter.
REQ-008 state  output  3  one-hot phase to decoder: [0] fetch, [1] exec1, [2] exec2; 000 when idle/halted.
REQ-009 inst  output  4  registered opcode (instruction register).
REQ-010 operand  output  4  registered operand.
REQ-011 pc_tload  output  1  one-cycle pulse: load pc from pc_target.
REQ-012 pc_target  output  8  subroutine call/return target.
REQ-013 halted  output  1  high while in HALT.
REQ-014 stack_err  output  1  sticky return-stack overflow/underflow flag.

Function
REQ-015 States: IDLE, FETCH, EXEC1, EXEC2, HALT; state output IDLE=000, FETCH=001, EXEC1=010, EXEC2=100, HALT=000.
REQ-016 IDLE -> FETCH when run=1; otherwise stay.
REQ-017 FETCH: wait while imem_ready=0; on imem_ready=1 capture inst<=imem_data[7:4], operand<=imem_data[3:0], go EXEC1.
REQ-018 EXEC1: opcode 0100 (STP) -> HALT; any other opcode -> EXEC2.
REQ-019 EXEC2 -> FETCH if run=1, else IDLE; the current instruction always completes regardless of run.
REQ-020 HALT: halted=1; leave to FETCH only on a run 0->1 transition sampled in HALT (registered run, previous cycle low, current high); run held high does not resume.
REQ-021 JMS (0110) in EXEC2, stack not full: push pc (the value at EXEC2, already incremented by the decoder in EXEC1), pc_target={4'h0,operand}, pc_tload=1.
REQ-022 BBL (0111) in EXEC2, stack not empty: pop, pc_target=popped entry, pc_tload=1.
REQ-023 JMS with DEPTH entries used: no push, pc_tload=0, stack_err<=1, next state HALT.
REQ-024 BBL with stack empty: no pop, pc_tload=0, stack_err<=1, next state HALT.
REQ-025 The stack is LIFO, occupancy counter 0..DEPTH; no wrap-around; entries are retained across HALT.
REQ-026 pc_tload is high only in EXEC2 cycles of a successful JMS/BBL; pc_target holds its last value otherwise.
REQ-027 state is exactly one-hot in FETCH/EXEC1/EXEC2 and never shows more than one bit set.
REQ-028 A run 0->1 transition in HALT does not clear stack_err; only reset clears it.
REQ-029 Opcodes other than STP/JMS/BBL take the FETCH/EXEC1/EXEC2 three-cycle path with no sequencer side-effects.

Reset
REQ-030 rst_n low asynchronously forces IDLE, state=000, inst=0, operand=0, pc_tload=0, pc_target=0, halted=0, stack_err=0, occupancy=0, registered run=0.
REQ-031 Reset asserted mid-instruction (any state) aborts that instruction; no push, pop or pc_tload completes.
REQ-032 After rst_n deasserts, the first FETCH occurs on the first edge with run=1.

Verification
REQ-033 run=1, imem_ready=1, imem_data=8'h15 -> state 001,010,100,001 on consecutive cycles; inst=4'h1, operand=4'h5.
REQ-034 imem_ready low 3 cycles in FETCH -> state holds 001 for 3 cycles; the 4th cycle (ready=1) captures the word and the next cycle shows 010.
REQ-035 imem_data=8'h40 (STP) -> EXEC1 then halted=1, state=000; run held high keeps HALT; run 1->0->1 -> FETCH next cycle.
REQ-036 JMS 8'h6A with pc=8'h23 -> pc_tload pulse, pc_target=8'h0A; later BBL 8'h70 -> pc_tload pulse, pc_target=8'h23.
REQ-037 Five nested JMS with DEPTH=4 -> fifth gives no pc_tload, stack_err=1, halted=1; BBL on empty stack after reset -> stack_err=1, halted=1.
REQ-038 rst_n pulsed low during EXEC2 of a JMS -> no pc_tload, all outputs at reset values immediately, occupancy 0.

Source files
------------

// File: rtl/sequencer.sv
// Instruction sequencer: fetch/exec phase FSM, instruction register,
// and subroutine return stack driving pc loads for JMS/BBL.
module sequencer #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [7:0] imem_data,
  input  logic       imem_ready,
  input  logic [7:0] pc,
  output logic [2:0] state,
  output logic [3:0] inst,
  output logic [3:0] operand,
  output logic       pc_tload,
  output logic [7:0] pc_target,
  output logic       halted,
  output logic       stack_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [3:0] OP_STP = 4'h4;
  localparam logic [3:0] OP_JMS = 4'h6;
  localparam logic [3:0] OP_BBL = 4'h7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC1,
    S_EXEC2,
    S_HALT
  } st_t;

  st_t cur, nxt;

  logic [7:0]    stk [DEPTH];
  logic [CW-1:0] cnt;
  logic [AW-1:0] top;
  logic          full, empty;
  logic          run_q;
  logic [7:0]    tgt_q, tgt_n;
  logic          push, pop, err;

  assign top   = AW'(cnt - CW'(1));
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // Next-state, stack control and pc load decisions
  always_comb begin
    nxt      = cur;
    pc_tload = 1'b0;
    tgt_n    = tgt_q;
    push     = 1'b0;
    pop      = 1'b0;
    err      = 1'b0;
    unique case (cur)
      S_IDLE:  if (run) nxt = S_FETCH;
      S_FETCH: if (imem_ready) nxt = S_EXEC1;
      S_EXEC1: nxt = (inst == OP_STP) ? S_HALT : S_EXEC2;
      S_EXEC2: begin
        nxt = run ? S_FETCH : S_IDLE;
        if (inst == OP_JMS) begin
          if (full) begin
            err = 1'b1;
            nxt = S_HALT;
          end else begin
            push     = 1'b1;
            pc_tload = 1'b1;
            tgt_n    = {4'h0, operand};
          end
        end else if (inst == OP_BBL) begin
          if (empty) begin
            err = 1'b1;
            nxt = S_HALT;
          end else begin
            pop      = 1'b1;
            pc_tload = 1'b1;
            tgt_n    = stk[top];
          end
        end
      end
      S_HALT:  if (run && !run_q) nxt = S_FETCH;
      default: nxt = S_IDLE;
    endcase
  end

  // One-hot phase output and halt indication
  always_comb begin
    state  = 3'b000;
    halted = 1'b0;
    unique case (cur)
      S_FETCH: state  = 3'b001;
      S_EXEC1: state  = 3'b010;
      S_EXEC2: state  = 3'b100;
      S_HALT:  halted = 1'b1;
      default: state  = 3'b000;
    endcase
  end

  // Target is presented combinationally during the load cycle, then held
  assign pc_target = pc_tload ? tgt_n : tgt_q;

  // State, instruction register, stack and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= S_IDLE;
      run_q     <= 1'b0;
      inst      <= '0;
      operand   <= '0;
      tgt_q     <= '0;
      cnt       <= '0;
      stack_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
    end else begin
      cur   <= nxt;
      run_q <= run;
      if (cur == S_FETCH && imem_ready) begin
        inst    <= imem_data[7:4];
        operand <= imem_data[3:0];
      end
      if (pc_tload) tgt_q <= tgt_n;
      if (push) begin
        stk[cnt[AW-1:0]] <= pc;
        cnt              <= cnt + CW'(1);
      end else if (pop) begin
        cnt <= cnt - CW'(1);
      end
      if (err) stack_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sequencer.sv
// Directed bench for sequencer: vector table for the main flow plus
// hand-written sequences for stack errors, resume and reset abort.
module tb_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [7:0] imem_data = '0;
  logic       imem_ready = 1'b0;
  logic [7:0] pc = '0;
  logic [2:0] state;
  logic [3:0] inst, operand;
  logic       pc_tload;
  logic [7:0] pc_target;
  logic       halted, stack_err;

  int passed = 0;
  int total  = 0;

  sequencer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_data(imem_data), .imem_ready(imem_ready), .pc(pc),
    .state(state), .inst(inst), .operand(operand),
    .pc_tload(pc_tload), .pc_target(pc_target),
    .halted(halted), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, rdy;
    logic [7:0] d, p;
    logic [2:0] st;
    logic [3:0] ins, opr;
    logic       tl;
    logic [7:0] tg;
    logic       hl, er;
  } vec_t;

  vec_t tv [24];

  function automatic vec_t mk(
    logic r, logic rdy, logic [7:0] d, logic [7:0] p,
    logic [2:0] st, logic [3:0] ins, logic [3:0] opr,
    logic tl, logic [7:0] tg, logic hl, logic er);
    vec_t v;
    v.r = r; v.rdy = rdy; v.d = d; v.p = p;
    v.st = st; v.ins = ins; v.opr = opr;
    v.tl = tl; v.tg = tg; v.hl = hl; v.er = er;
    return v;
  endfunction

  task automatic chk(string nm, logic [7:0] a, logic [7:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %02h expected %02h at %0t",
                  nm, a, e, $time);
  endtask

  task automatic step(logic r, logic rdy,
                      logic [7:0] d, logic [7:0] p);
    @(negedge clk);
    run = r; imem_ready = rdy; imem_data = d; pc = p;
    #1;
  endtask

  task automatic chk_rst(string nm);
    chk({nm, ".state"}, {5'd0, state}, 8'h00);
    chk({nm, ".inst"}, {4'd0, inst}, 8'h00);
    chk({nm, ".operand"}, {4'd0, operand}, 8'h00);
    chk({nm, ".tload"}, {7'd0, pc_tload}, 8'h00);
    chk({nm, ".target"}, pc_target, 8'h00);
    chk({nm, ".halted"}, {7'd0, halted}, 8'h00);
    chk({nm, ".err"}, {7'd0, stack_err}, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; run = 1'b0; imem_ready = 1'b0;
    imem_data = '0; pc = '0;
    #1;
    chk_rst("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    //          run rdy data  pc    st    ins   op    tl tg    h  e
    tv[0]  = mk(0, 0, 8'h00, 8'h00, 3'd0, 4'h0, 4'h0, 0, 8'h00, 0, 0);
    tv[1]  = mk(1, 1, 8'h15, 8'h00, 3'd0, 4'h0, 4'h0, 0, 8'h00, 0, 0);
    tv[2]  = mk(1, 1, 8'h15, 8'h00, 3'd1, 4'h0, 4'h0, 0, 8'h00, 0, 0);
    tv[3]  = mk(1, 1, 8'h15, 8'h00, 3'd2, 4'h1, 4'h5, 0, 8'h00, 0, 0);
    tv[4]  = mk(1, 0, 8'h00, 8'h00, 3'd4, 4'h1, 4'h5, 0, 8'h00, 0, 0);
    tv[5]  = mk(1, 0, 8'h00, 8'h00, 3'd1, 4'h1, 4'h5, 0, 8'h00, 0, 0);
    tv[6]  = mk(1, 0, 8'h00, 8'h00, 3'd1, 4'h1, 4'h5, 0, 8'h00, 0, 0);
    tv[7]  = mk(1, 0, 8'h00, 8'h00, 3'd1, 4'h1, 4'h5, 0, 8'h00, 0, 0);
    tv[8]  = mk(1, 1, 8'h6A, 8'h00, 3'd1, 4'h1, 4'h5, 0, 8'h00, 0, 0);
    tv[9]  = mk(1, 1, 8'h00, 8'h00, 3'd2, 4'h6, 4'hA, 0, 8'h00, 0, 0);
    tv[10] = mk(1, 1, 8'h00, 8'h23, 3'd4, 4'h6, 4'hA, 1, 8'h0A, 0, 0);
    tv[11] = mk(1, 1, 8'h70, 8'h24, 3'd1, 4'h6, 4'hA, 0, 8'h0A, 0, 0);
    tv[12] = mk(1, 1, 8'h00, 8'h10, 3'd2, 4'h7, 4'h0, 0, 8'h0A, 0, 0);
    tv[13] = mk(1, 1, 8'h00, 8'h10, 3'd4, 4'h7, 4'h0, 1, 8'h23, 0, 0);
    tv[14] = mk(1, 1, 8'h40, 8'h00, 3'd1, 4'h7, 4'h0, 0, 8'h23, 0, 0);
    tv[15] = mk(1, 1, 8'h00, 8'h00, 3'd2, 4'h4, 4'h0, 0, 8'h23, 0, 0);
    tv[16] = mk(1, 1, 8'h00, 8'h00, 3'd0, 4'h4, 4'h0, 0, 8'h23, 1, 0);
    tv[17] = mk(1, 0, 8'h00, 8'h00, 3'd0, 4'h4, 4'h0, 0, 8'h23, 1, 0);
    tv[18] = mk(0, 0, 8'h00, 8'h00, 3'd0, 4'h4, 4'h0, 0, 8'h23, 1, 0);
    tv[19] = mk(1, 0, 8'h00, 8'h00, 3'd0, 4'h4, 4'h0, 0, 8'h23, 1, 0);
    tv[20] = mk(0, 1, 8'h15, 8'h00, 3'd1, 4'h4, 4'h0, 0, 8'h23, 0, 0);
    tv[21] = mk(0, 1, 8'h00, 8'h00, 3'd2, 4'h1, 4'h5, 0, 8'h23, 0, 0);
    tv[22] = mk(0, 0, 8'h00, 8'h00, 3'd4, 4'h1, 4'h5, 0, 8'h23, 0, 0);
    tv[23] = mk(0, 0, 8'h00, 8'h00, 3'd0, 4'h1, 4'h5, 0, 8'h23, 0, 0);

    repeat (2) @(negedge clk);
    chk_rst("por");
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      step(tv[i].r, tv[i].rdy, tv[i].d, tv[i].p);
      chk($sformatf("v%0d.state", i), {5'd0, state}, {5'd0, tv[i].st});
      chk($sformatf("v%0d.inst", i), {4'd0, inst}, {4'd0, tv[i].ins});
      chk($sformatf("v%0d.op", i), {4'd0, operand}, {4'd0, tv[i].opr});
      chk($sformatf("v%0d.tload", i), {7'd0, pc_tload}, {7'd0, tv[i].tl});
      chk($sformatf("v%0d.target", i), pc_target, tv[i].tg);
      chk($sformatf("v%0d.halted", i), {7'd0, halted}, {7'd0, tv[i].hl});
      chk($sformatf("v%0d.err", i), {7'd0, stack_err}, {7'd0, tv[i].er});
    end

    // BBL on an empty stack, then resume keeps the sticky error
    do_reset();
    step(1, 1, 8'h70, 8'h00);
    chk("ue.idle", {5'd0, state}, 8'h00);
    step(1, 1, 8'h70, 8'h00);
    chk("ue.fetch", {5'd0, state}, 8'h01);
    step(1, 1, 8'h00, 8'h00);
    chk("ue.exec1", {5'd0, state}, 8'h02);
    step(1, 1, 8'h00, 8'h00);
    chk("ue.exec2", {5'd0, state}, 8'h04);
    chk("ue.tload", {7'd0, pc_tload}, 8'h00);
    step(1, 0, 8'h00, 8'h00);
    chk("ue.halted", {7'd0, halted}, 8'h01);
    chk("ue.err", {7'd0, stack_err}, 8'h01);
    chk("ue.hstate", {5'd0, state}, 8'h00);
    step(0, 0, 8'h00, 8'h00);
    step(1, 0, 8'h00, 8'h00);
    chk("ue.still", {7'd0, halted}, 8'h01);
    step(1, 0, 8'h00, 8'h00);
    chk("ue.resume", {5'd0, state}, 8'h01);
    chk("ue.sticky", {7'd0, stack_err}, 8'h01);

    // Five nested JMS overflow a 4-deep stack; entries survive HALT
    do_reset();
    step(1, 0, 8'h00, 8'h00);
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 8'h61 + 8'(k), 8'h00);
      chk($sformatf("ov%0d.fetch", k), {5'd0, state}, 8'h01);
      step(1, 1, 8'h00, 8'h00);
      chk($sformatf("ov%0d.inst", k), {4'd0, inst}, 8'h06);
      step(1, 1, 8'h00, 8'h30 + 8'(k));
      chk($sformatf("ov%0d.exec2", k), {5'd0, state}, 8'h04);
      if (k < 4) begin
        chk($sformatf("ov%0d.tload", k), {7'd0, pc_tload}, 8'h01);
        chk($sformatf("ov%0d.target", k), pc_target, 8'h01 + 8'(k));
      end else begin
        chk("ov4.tload", {7'd0, pc_tload}, 8'h00);
        chk("ov4.target", pc_target, 8'h04);
      end
    end
    step(1, 0, 8'h00, 8'h00);
    chk("ov.halted", {7'd0, halted}, 8'h01);
    chk("ov.err", {7'd0, stack_err}, 8'h01);
    step(0, 0, 8'h00, 8'h00);
    step(1, 0, 8'h00, 8'h00);
    step(1, 1, 8'h70, 8'h00);
    chk("ov.refetch", {5'd0, state}, 8'h01);
    step(1, 1, 8'h00, 8'h00);
    step(1, 1, 8'h00, 8'h00);
    chk("ov.pop.tload", {7'd0, pc_tload}, 8'h01);
    chk("ov.pop.target", pc_target, 8'h33);

    // Reset during EXEC2 of a JMS aborts the push and the load
    do_reset();
    step(1, 0, 8'h00, 8'h00);
    step(1, 1, 8'h6C, 8'h00);
    step(1, 1, 8'h00, 8'h00);
    step(1, 1, 8'h00, 8'h55);
    chk("ab.exec2", {5'd0, state}, 8'h04);
    chk("ab.pre.tload", {7'd0, pc_tload}, 8'h01);
    #1 rst_n = 1'b0;
    #1 chk_rst("ab.async");
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 8'h70, 8'h00);
    step(1, 1, 8'h70, 8'h00);
    step(1, 1, 8'h00, 8'h00);
    step(1, 1, 8'h00, 8'h00);
    chk("ab.bbl.tload", {7'd0, pc_tload}, 8'h00);
    step(1, 0, 8'h00, 8'h00);
    chk("ab.empty.err", {7'd0, stack_err}, 8'h01);
    chk("ab.empty.halt", {7'd0, halted}, 8'h01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
